osd_status_udp_tx: RTL and testbench

- Transmit-side counterpart of the UDP character receive path that feeds the OSD.
- Snapshots the current OSD control state (channel_index, angle_num, scale_num), converts it to a fixed 27-byte ASCII status line, and streams it byte-wise to the UDP transmit engine.
- The host PC can therefore read back the settings the OSD is currently showing.
- Sits in the sys_clk domain, beside the ethernet receive logic, and drives the UDP application TX byte interface.

---
 rtl/osd_status_udp_tx.sv | 208 ++++++++++++++++++++
 tb/tb_osd_status_udp_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_status_udp_tx.sv
// Snapshots the OSD control state and streams it to the UDP TX byte interface
// as the 27-byte ASCII line "CH:c ANG:aaa SCL:iii.ffff\r\n".
module osd_status_udp_tx #(
    parameter logic [31:0] PERIOD_CYCLES = 32'd125_000_000,
    parameter bit          CHANGE_DETECT = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        send_trig,
    input  logic [2:0]  channel_index,
    input  logic [8:0]  angle_num,
    input  logic [10:0] scale_num,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic [15:0] tx_len,
    output logic        tx_busy,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_CONVERT, S_SEND, S_DONE
    } state_t;

    state_t      state_q;
    logic        pend_q;
    logic [31:0] per_q;
    logic [2:0]  sh_ch_q, ch_q;
    logic [8:0]  sh_ang_q, ang_q;
    logic [10:0] sh_scl_q, scl_q;
    logic [13:0] ang_op_q, int_op_q, frac_op_q;
    logic [15:0] ang_bcd_q, int_bcd_q, frac_bcd_q;
    logic [3:0]  cvt_cnt_q;
    logic [4:0]  idx_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q, tx_last_q, busy_q;
    logic [15:0] pkt_cnt_q;

    logic        period_hit, changed, trig_ext, trig_idle;
    logic [4:0]  idx_d;
    logic [7:0]  byte_d;
    logic [13:0] frac_val;

    // One double-dabble step: add-3 on digits >= 5, then shift in the next bit.
    function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic b);
        logic [15:0] adj;
        adj = bcd;
        for (int k = 0; k < 4; k++) begin
            if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        return {adj[14:0], b};
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    assign period_hit = (PERIOD_CYCLES != 32'd0) && (per_q == PERIOD_CYCLES - 32'd1);
    assign changed    = CHANGE_DETECT &&
                        ({channel_index, angle_num, scale_num} != {sh_ch_q, sh_ang_q, sh_scl_q});
    assign trig_ext   = send_trig | period_hit | changed;
    assign trig_idle  = trig_ext | pend_q;

    // fraction * 625 as shift-add: 512 + 64 + 32 + 16 + 1
    assign frac_val = {1'b0, scl_q[3:0], 9'b0} + {4'b0, scl_q[3:0], 6'b0} +
                      {5'b0, scl_q[3:0], 5'b0} + {6'b0, scl_q[3:0], 4'b0} +
                      {10'b0, scl_q[3:0]};

    assign idx_d = idx_q + 5'd1;

    always_comb begin
        byte_d = 8'h00;
        case (idx_d)
            5'd0:  byte_d = "C";
            5'd1:  byte_d = "H";
            5'd2:  byte_d = ":";
            5'd3:  byte_d = 8'h30 + {5'b0, ch_q};
            5'd4:  byte_d = " ";
            5'd5:  byte_d = "A";
            5'd6:  byte_d = "N";
            5'd7:  byte_d = "G";
            5'd8:  byte_d = ":";
            5'd9:  byte_d = asc(ang_bcd_q[11:8]);
            5'd10: byte_d = asc(ang_bcd_q[7:4]);
            5'd11: byte_d = asc(ang_bcd_q[3:0]);
            5'd12: byte_d = " ";
            5'd13: byte_d = "S";
            5'd14: byte_d = "C";
            5'd15: byte_d = "L";
            5'd16: byte_d = ":";
            5'd17: byte_d = asc(int_bcd_q[11:8]);
            5'd18: byte_d = asc(int_bcd_q[7:4]);
            5'd19: byte_d = asc(int_bcd_q[3:0]);
            5'd20: byte_d = ".";
            5'd21: byte_d = asc(frac_bcd_q[15:12]);
            5'd22: byte_d = asc(frac_bcd_q[11:8]);
            5'd23: byte_d = asc(frac_bcd_q[7:4]);
            5'd24: byte_d = asc(frac_bcd_q[3:0]);
            5'd25: byte_d = 8'h0D;
            5'd26: byte_d = 8'h0A;
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_q     <= 1'b0;
            per_q      <= 32'd0;
            sh_ch_q    <= 3'd0;
            sh_ang_q   <= 9'd0;
            sh_scl_q   <= 11'd0;
            ch_q       <= 3'd0;
            ang_q      <= 9'd0;
            scl_q      <= 11'd0;
            ang_op_q   <= 14'd0;
            int_op_q   <= 14'd0;
            frac_op_q  <= 14'd0;
            ang_bcd_q  <= 16'd0;
            int_bcd_q  <= 16'd0;
            frac_bcd_q <= 16'd0;
            cvt_cnt_q  <= 4'd0;
            idx_q      <= 5'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            if (period_hit) per_q <= 32'd0;
            else if (PERIOD_CYCLES != 32'd0) per_q <= per_q + 32'd1;

            case (state_q)
                S_IDLE: begin
                    if (trig_idle) begin
                        state_q  <= S_CAPTURE;
                        busy_q   <= 1'b1;
                        pend_q   <= 1'b0;
                        ch_q     <= channel_index;
                        ang_q    <= angle_num;
                        scl_q    <= scale_num;
                        sh_ch_q  <= channel_index;
                        sh_ang_q <= angle_num;
                        sh_scl_q <= scale_num;
                    end
                end
                S_CAPTURE: begin
                    // Short operands carry leading zeros, which shift through harmlessly.
                    ang_op_q   <= {5'b0, ang_q};
                    int_op_q   <= {7'b0, scl_q[10:4]};
                    frac_op_q  <= frac_val;
                    ang_bcd_q  <= 16'd0;
                    int_bcd_q  <= 16'd0;
                    frac_bcd_q <= 16'd0;
                    cvt_cnt_q  <= 4'd0;
                    state_q    <= S_CONVERT;
                end
                S_CONVERT: begin
                    ang_bcd_q  <= dd_step(ang_bcd_q, ang_op_q[13]);
                    int_bcd_q  <= dd_step(int_bcd_q, int_op_q[13]);
                    frac_bcd_q <= dd_step(frac_bcd_q, frac_op_q[13]);
                    ang_op_q   <= {ang_op_q[12:0], 1'b0};
                    int_op_q   <= {int_op_q[12:0], 1'b0};
                    frac_op_q  <= {frac_op_q[12:0], 1'b0};
                    cvt_cnt_q  <= cvt_cnt_q + 4'd1;
                    if (cvt_cnt_q == 4'd13) begin
                        state_q    <= S_SEND;
                        idx_q      <= 5'd0;
                        tx_data_q  <= "C";
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (tx_valid_q && tx_ready) begin
                        if (idx_q == 5'd26) begin
                            state_q    <= S_DONE;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= byte_d;
                            tx_last_q <= (idx_d == 5'd26);
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // While busy, any request collapses into a single deferred report.
            if (state_q != S_IDLE && trig_ext) pend_q <= 1'b1;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign tx_len   = 16'd27;
    assign tx_busy  = busy_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_osd_status_udp_tx.sv
// Directed bench for osd_status_udp_tx: manual/change-driven instance plus a
// periodic instance, each packet checked byte by byte against literal lines.
module tb_osd_status_udp_tx;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1, send_trig = 1'b0, tx_ready = 1'b1;
    logic [2:0]  ch = '0;
    logic [8:0]  ang = '0;
    logic [10:0] scl = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, tx_busy;
    logic [15:0] tx_len, pkt_cnt;

    logic        rst_b = 1'b1, send_trig_b = 1'b0, tx_ready_b = 1'b1;
    logic [2:0]  ch_b = '0;
    logic [8:0]  ang_b = '0;
    logic [10:0] scl_b = '0;
    logic [7:0]  tx_data_b;
    logic        tx_valid_b, tx_last_b, tx_busy_b;
    logic [15:0] tx_len_b, pkt_cnt_b;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    osd_status_udp_tx #(.PERIOD_CYCLES(32'd0), .CHANGE_DETECT(1'b1)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .send_trig(send_trig),
        .channel_index(ch), .angle_num(ang), .scale_num(scl),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .tx_len(tx_len), .tx_busy(tx_busy), .pkt_cnt(pkt_cnt)
    );

    osd_status_udp_tx #(.PERIOD_CYCLES(32'd1000), .CHANGE_DETECT(1'b1)) dut_b (
        .sys_clk(sys_clk), .rst(rst_b), .send_trig(send_trig_b),
        .channel_index(ch_b), .angle_num(ang_b), .scale_num(scl_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .tx_last(tx_last_b), .tx_len(tx_len_b), .tx_busy(tx_busy_b), .pkt_cnt(pkt_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input string s);
        for (int i = 0; i < 25; i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Pulse send_trig together with new inputs; returns #1 after the trigger edge.
    task automatic start_pkt(input logic [2:0] c, input logic [8:0] a, input logic [10:0] s);
        @(negedge sys_clk);
        rst = 1'b0;
        ch = c; ang = a; scl = s;
        send_trig = 1'b1;
        @(posedge sys_clk);
        #1 send_trig = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        repeat (14) @(posedge sys_clk);
        #1 check({tag, " valid_before_16"}, tx_valid, 1'b0);
        @(posedge sys_clk);
        #1 check({tag, " valid_at_16"}, tx_valid, 1'b1);
    endtask

    task automatic recv_pkt(input string tag, input int duty, input bit b2b);
        int hs = 0;
        int cyc = 0;
        int first = -1;
        bit pstall = 1'b0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        while (hs < 27 && cyc < 3000) begin
            @(negedge sys_clk);
            cyc++;
            if (pstall) begin
                check($sformatf("%s hold_data%0d", tag, hs), tx_data, pd);
                check($sformatf("%s hold_last%0d", tag, hs), tx_last, pl);
            end
            tx_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            if (tx_valid && tx_ready) begin
                if (first < 0) first = cyc;
                check($sformatf("%s byte%0d", tag, hs), tx_data, exp_q.pop_front());
                check($sformatf("%s last%0d", tag, hs), tx_last, (hs == 26));
                hs++;
            end
            pstall = tx_valid && !tx_ready;
            pd = tx_data;
            pl = tx_last;
        end
        check({tag, " handshakes"}, hs, 27);
        if (b2b) check({tag, " back_to_back_span"}, cyc - first + 1, 27);
        @(posedge sys_clk);
        #1 tx_ready = 1'b1;
    endtask

    task automatic count_valid_rises(input int cycles, output int rises);
        logic prev = 1'b0;
        rises = 0;
        repeat (cycles) begin
            @(negedge sys_clk);
            if (tx_valid && !prev) rises++;
            prev = tx_valid;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int n;
        int r1;
        int r2;
        logic prev;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst tx_valid", tx_valid, 1'b0);
        check("rst tx_data", tx_data, 8'h00);
        check("rst tx_last", tx_last, 1'b0);
        check("rst tx_busy", tx_busy, 1'b0);
        check("rst pkt_cnt", pkt_cnt, 16'd0);
        check("tx_len", tx_len, 16'd27);
        rst = 1'b0;
        count_valid_rises(20, rises);
        check("idle after rst", rises, 0);

        // 1: basic packet, latency and back-to-back
        load_exp("CH:3 ANG:123 SCL:045.5000");
        start_pkt(3'd3, 9'd123, 11'h2D8);
        check_latency("t1");
        recv_pkt("t1", 100, 1'b1);
        repeat (3) @(posedge sys_clk);
        #1 check("t1 pkt_cnt", pkt_cnt, 16'd1);
        check("t1 busy_low", tx_busy, 1'b0);

        // 2: extremes
        load_exp("CH:7 ANG:511 SCL:127.9375");
        start_pkt(3'd7, 9'd511, 11'h7FF);
        recv_pkt("t2max", 100, 1'b1);
        repeat (3) @(posedge sys_clk);
        load_exp("CH:0 ANG:000 SCL:000.0000");
        start_pkt(3'd0, 9'd0, 11'h000);
        recv_pkt("t2zero", 100, 1'b1);
        repeat (3) @(posedge sys_clk);
        #1 check("t2 pkt_cnt", pkt_cnt, 16'd3);

        // 3: throttled ready
        load_exp("CH:1 ANG:037 SCL:060.0625");
        start_pkt(3'd1, 9'd37, 11'h3C1);
        recv_pkt("t3", 30, 1'b0);
        count_valid_rises(60, rises);
        check("t3 no_extra", rises, 0);
        check("t3 pkt_cnt", pkt_cnt, 16'd4);

        // 4: triggers and input change during SEND merge into one extra packet
        @(negedge sys_clk);
        rst = 1'b1; ch = '0; ang = '0; scl = '0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        load_exp("CH:5 ANG:100 SCL:010.2500");
        start_pkt(3'd5, 9'd100, 11'h0A4);
        fork
            recv_pkt("t4a", 100, 1'b1);
            begin
                repeat (20) @(negedge sys_clk);
                send_trig = 1'b1;
                @(negedge sys_clk) send_trig = 1'b0;
                @(negedge sys_clk) ang = 9'd200;
                @(negedge sys_clk) send_trig = 1'b1;
                @(negedge sys_clk) send_trig = 1'b0;
                repeat (2) @(negedge sys_clk);
                send_trig = 1'b1;
                @(negedge sys_clk) send_trig = 1'b0;
            end
        join
        load_exp("CH:5 ANG:200 SCL:010.2500");
        recv_pkt("t4b", 100, 1'b1);
        count_valid_rises(200, rises);
        check("t4 no_third", rises, 0);
        check("t4 pkt_cnt", pkt_cnt, 16'd2);

        // 5: periodic instance, then change-detect latency
        @(negedge sys_clk);
        rst_b = 1'b0;
        n = 0; r1 = -1; r2 = -1; prev = 1'b0;
        while (r2 < 0 && n < 2500) begin
            @(posedge sys_clk);
            n++;
            #1;
            if (tx_valid_b && !prev) begin
                if (r1 < 0) r1 = n;
                else r2 = n;
            end
            prev = tx_valid_b;
        end
        check("t5 first_period", r1, 1015);
        check("t5 period_spacing", r2 - r1, 1000);
        repeat (100) @(posedge sys_clk);
        @(negedge sys_clk);
        scl_b = 11'h123;
        @(posedge sys_clk);
        repeat (14) @(posedge sys_clk);
        #1 check("t5 chg valid_before_16", tx_valid_b, 1'b0);
        @(posedge sys_clk);
        #1 check("t5 chg valid_at_16", tx_valid_b, 1'b1);
        repeat (60) @(posedge sys_clk);
        #1 check("t5 pkt_cnt_b", pkt_cnt_b, 16'd3);
        count_valid_rises(2000, rises);
        check("t5 no_period_when_0", rises, 0);

        // 6: reset at byte index 10, then a clean packet
        start_pkt(3'd6, 9'd300, 11'h155);
        n = 0;
        while (n < 10) begin
            @(negedge sys_clk);
            if (tx_valid) n++;
        end
        @(negedge sys_clk);
        rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("t6 valid", tx_valid, 1'b0);
        check("t6 busy", tx_busy, 1'b0);
        check("t6 last", tx_last, 1'b0);
        check("t6 pkt_cnt", pkt_cnt, 16'd0);
        load_exp("CH:2 ANG:045 SCL:001.1875");
        start_pkt(3'd2, 9'd45, 11'h013);
        check_latency("t6");
        recv_pkt("t6", 100, 1'b1);
        repeat (3) @(posedge sys_clk);
        #1 check("t6 pkt_cnt_after", pkt_cnt, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
